uzorak_punjac: RTL and testbench

Assembles one 60-feature sonar sample from a serial stream of 16-bit words into the 960-bit parallel vector consumed by the fixed-weight neuron stage. Sits directly upstream of each neuron instance and drives its `uzorak` input. Tracks the neuron's fixed pipeline latency and flags the cycle in which the neuron's `izlaz` belongs to the transferred sample. The fill buffer is double-buffered, so the next sample streams in while the current one is evaluated.

---
 rtl/uzorak_pkg.sv | 17 +
 rtl/uzorak_punjac_if.sv | 24 ++
 rtl/brojac_latencije.sv | 40 ++++
 rtl/uzorak_punjac.sv | 105 ++++++++++
 tb/tb_uzorak_punjac.sv | 222 ++++++++++++++++++++++
 5 files changed

// File: rtl/uzorak_pkg.sv
// Shared constants, index type and FSM states for the sonar sample packer.
package uzorak_pkg;

    localparam int unsigned BROJ_ZNACAJKI  = 60;
    localparam int unsigned SIRINA         = 16;
    localparam int unsigned SIRINA_UZORKA  = BROJ_ZNACAJKI * SIRINA;
    localparam int unsigned SIRINA_INDEKSA = $clog2(BROJ_ZNACAJKI);
    localparam int unsigned SIRINA_POMAKA  = $clog2(SIRINA_UZORKA);

    typedef logic [SIRINA_INDEKSA-1:0] indeks_t;

    typedef enum logic {
        PUNJENJE,
        CEKANJE
    } stanje_e;

endpackage

// File: rtl/uzorak_punjac_if.sv
// Word stream in, parallel sample and status pulses out toward the neuron.
interface uzorak_punjac_if;
    import uzorak_pkg::*;

    logic [SIRINA-1:0]        ulaz_podatak;
    logic                     ulaz_valid;
    logic                     ulaz_zadnji;
    logic                     ulaz_ready;
    logic [SIRINA_UZORKA-1:0] uzorak;
    logic                     uzorak_valid;
    logic                     rezultat_valid;
    logic                     greska;

    modport master (
        output ulaz_podatak, ulaz_valid, ulaz_zadnji,
        input  ulaz_ready, uzorak, uzorak_valid, rezultat_valid, greska
    );

    modport slave (
        input  ulaz_podatak, ulaz_valid, ulaz_zadnji,
        output ulaz_ready, uzorak, uzorak_valid, rezultat_valid, greska
    );

endinterface

// File: rtl/brojac_latencije.sv
// Counts down the neuron pipeline latency after each transfer and pulses
// rezultat_valid on the edge where the count expires.
module brojac_latencije #(
    parameter int unsigned LATENCIJA = 3
) (
    input  logic clk,
    input  logic rst_n,
    input  logic ucitaj,
    output logic nula,
    output logic rezultat_valid
);

    logic [7:0] brojac_q, brojac_d;
    logic       rezultat_valid_q;

    always_comb begin
        brojac_d = brojac_q;
        if (ucitaj) begin
            brojac_d = 8'(LATENCIJA);
        end else if (brojac_q != 8'd0) begin
            brojac_d = brojac_q - 8'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            brojac_q         <= 8'd0;
            rezultat_valid_q <= 1'b0;
        end else begin
            brojac_q         <= brojac_d;
            rezultat_valid_q <= (brojac_q == 8'd1);
        end
    end

    // Counter is zero after this edge, so a new sample may be loaded on it;
    // at 1 the neuron captures the old result on the same edge as the swap.
    assign nula           = (brojac_q <= 8'd1);
    assign rezultat_valid = rezultat_valid_q;

endmodule

// File: rtl/uzorak_punjac.sv
// Packs 60 serial 16-bit features into one 960-bit neuron sample (double-buffered).
// Optional frame checking on ulaz_zadnji: define UZORAK_PUNJAC_OKVIR_EN.
module uzorak_punjac
    import uzorak_pkg::*;
#(
    parameter int unsigned LATENCIJA = 3
) (
    input logic            clk,
    input logic            rst_n,
    uzorak_punjac_if.slave bus
);

    stanje_e                  stanje_q, stanje_d;
    indeks_t                  indeks_q, indeks_d;
    logic [SIRINA_UZORKA-1:0] spremnik_q, spremnik_d;
    logic [SIRINA_UZORKA-1:0] uzorak_q;
    logic [SIRINA_POMAKA-1:0] pomak;
    logic                     uzorak_valid_q, greska_q;
    logic                     prihvat, zadnja_rijec, okvir_greska, prenos, nula;

    assign bus.ulaz_ready = (stanje_q == PUNJENJE);
    assign prihvat        = bus.ulaz_valid && bus.ulaz_ready;
    assign zadnja_rijec   = (indeks_q == indeks_t'(BROJ_ZNACAJKI - 1));
    assign pomak          = SIRINA_POMAKA'(indeks_q) * SIRINA_POMAKA'(SIRINA);

`ifdef UZORAK_PUNJAC_OKVIR_EN
    assign okvir_greska = prihvat && (bus.ulaz_zadnji != zadnja_rijec);
`else
    logic unused_zadnji;
    assign unused_zadnji = bus.ulaz_zadnji;
    assign okvir_greska  = 1'b0;
`endif

    always_comb begin
        spremnik_d = spremnik_q;
        if (prihvat) begin
            spremnik_d[pomak +: SIRINA] = bus.ulaz_podatak;
        end
    end

    always_comb begin
        stanje_d = stanje_q;
        indeks_d = indeks_q;
        prenos   = 1'b0;
        unique case (stanje_q)
            PUNJENJE: begin
                if (prihvat) begin
                    if (okvir_greska) begin
                        indeks_d = '0;
                    end else if (zadnja_rijec) begin
                        indeks_d = '0;
                        if (nula) begin
                            prenos = 1'b1;
                        end else begin
                            stanje_d = CEKANJE;
                        end
                    end else begin
                        indeks_d = indeks_q + 1'b1;
                    end
                end
            end
            CEKANJE: begin
                if (nula) begin
                    prenos   = 1'b1;
                    stanje_d = PUNJENJE;
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stanje_q       <= PUNJENJE;
            indeks_q       <= '0;
            spremnik_q     <= '0;
            uzorak_q       <= '0;
            uzorak_valid_q <= 1'b0;
            greska_q       <= 1'b0;
        end else begin
            stanje_q       <= stanje_d;
            indeks_q       <= indeks_d;
            spremnik_q     <= spremnik_d;
            uzorak_valid_q <= prenos;
            greska_q       <= okvir_greska;
            if (prenos) begin
                uzorak_q <= spremnik_d;
            end
        end
    end

    brojac_latencije #(
        .LATENCIJA(LATENCIJA)
    ) u_brojac (
        .clk           (clk),
        .rst_n         (rst_n),
        .ucitaj        (prenos),
        .nula          (nula),
        .rezultat_valid(bus.rezultat_valid)
    );

    assign bus.uzorak       = uzorak_q;
    assign bus.uzorak_valid = uzorak_valid_q;
    assign bus.greska       = greska_q;

endmodule

// File: tb/tb_uzorak_punjac.sv
// Directed bench for uzorak_punjac: two instances (latency 3 and 100) share
// one stimulus stream; a scoreboard checks samples and pulse timing.
module tb_uzorak_punjac;
    import uzorak_pkg::*;

    localparam int LAT_A = 3;
    localparam int LAT_B = 100;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    uzorak_punjac_if bus_a ();
    uzorak_punjac_if bus_b ();

    logic [SIRINA-1:0] podatak = '0;
    logic valid = 1'b0, zadnji = 1'b0, sel = 1'b0;

    assign bus_a.ulaz_podatak = podatak;
    assign bus_a.ulaz_zadnji  = zadnji;
    assign bus_a.ulaz_valid   = valid && !sel;
    assign bus_b.ulaz_podatak = podatak;
    assign bus_b.ulaz_zadnji  = zadnji;
    assign bus_b.ulaz_valid   = valid && sel;

    uzorak_punjac #(.LATENCIJA(LAT_A)) dut_a (.clk(clk), .rst_n(rst_n), .bus(bus_a));
    uzorak_punjac #(.LATENCIJA(LAT_B)) dut_b (.clk(clk), .rst_n(rst_n), .bus(bus_b));

    logic                     rdy, uv, rv, gr;
    logic [SIRINA_UZORKA-1:0] uz;
    int                       lat;
    assign rdy = sel ? bus_b.ulaz_ready     : bus_a.ulaz_ready;
    assign uv  = sel ? bus_b.uzorak_valid   : bus_a.uzorak_valid;
    assign rv  = sel ? bus_b.rezultat_valid : bus_a.rezultat_valid;
    assign gr  = sel ? bus_b.greska         : bus_a.greska;
    assign uz  = sel ? bus_b.uzorak         : bus_a.uzorak;
    assign lat = sel ? LAT_B : LAT_A;

    int checks = 0, passed = 0;
    int cyc = 0;
    int niski_a = 0, niski_b = 0;
    int zadnji_prijenos = -1000;

    logic [SIRINA_UZORKA-1:0] q_vec[$];
    int q_xfer[$], q_rez[$], q_gr[$];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic provjeri(input string tag, input logic [SIRINA_UZORKA-1:0] got,
                            input logic [SIRINA_UZORKA-1:0] exp);
        checks++;
        assert (got === exp) begin
            passed++;
        end else begin
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    // Output monitor, sampled mid-cycle; cyc equals the edge just taken.
    always @(negedge clk) begin
        if (rst_n) begin
            if (!bus_a.ulaz_ready) niski_a <= niski_a + 1;
            if (!bus_b.ulaz_ready) niski_b <= niski_b + 1;
            if (uv) begin
                provjeri("uzorak_valid expected", q_vec.size() != 0, 1);
                if (q_vec.size() != 0) begin
                    provjeri("uzorak", uz, q_vec.pop_front());
                    provjeri("transfer edge", cyc, q_xfer.pop_front());
                end
            end
            if (rv) begin
                provjeri("rezultat_valid expected", q_rez.size() != 0, 1);
                if (q_rez.size() != 0) provjeri("rezultat edge", cyc, q_rez.pop_front());
            end
            if (gr) begin
                provjeri("greska expected", q_gr.size() != 0, 1);
                if (q_gr.size() != 0) provjeri("greska edge", cyc, q_gr.pop_front());
            end
        end
    end

    task automatic mir(input int n);
        repeat (n) begin
            @(negedge clk);
            valid  = 1'b0;
            zadnji = 1'b0;
        end
    endtask

    // Drives one word and returns the edge on which it was accepted.
    task automatic posalji(input logic [SIRINA-1:0] d, input logic z, output int t);
        int n = 0;
        bit gotovo = 0;
        logic r;
        t = -1;
        while (!gotovo) begin
            @(negedge clk);
            podatak = d;
            zadnji  = z;
            valid   = 1'b1;
            r       = rdy;
            t       = cyc + 1;
            @(posedge clk);
            if (r) begin
                gotovo = 1;
            end else if (++n > 300) begin
                provjeri("ulaz_ready timeout", n, 0);
                gotovo = 1;
            end
        end
    endtask

    task automatic okvir(input int baza, input bit razmak, input int zad, input int n,
                         output int t0, output int t1);
        logic [SIRINA_UZORKA-1:0] v = '0;
        int t = 0;
        int x;
        t0 = 0;
        for (int k = 0; k < n; k++) begin
            if (razmak && k > 0) mir(1);
            posalji(SIRINA'(baza + k), k == zad, t);
            if (k == 0) t0 = t;
            v = v | (SIRINA_UZORKA'(SIRINA'(baza + k)) << (k * SIRINA));
        end
        t1 = t;
`ifdef UZORAK_PUNJAC_OKVIR_EN
        if (zad != BROJ_ZNACAJKI - 1) begin
            q_gr.push_back(t1);
            return;
        end
`endif
        if (n == BROJ_ZNACAJKI) begin
            x = (t1 > zadnji_prijenos + lat) ? t1 : zadnji_prijenos + lat;
            q_vec.push_back(v);
            q_xfer.push_back(x);
            q_rez.push_back(x + lat);
            zadnji_prijenos = x;
        end
    endtask

    task automatic resetiraj();
        @(negedge clk);
        rst_n  = 1'b0;
        valid  = 1'b0;
        zadnji = 1'b0;
        q_vec.delete();
        q_xfer.delete();
        q_rez.delete();
        zadnji_prijenos = -1000;
        repeat (2) @(negedge clk);
        provjeri("reset uzorak", uz, '0);
        provjeri("reset uzorak_valid", uv, 0);
        provjeri("reset rezultat_valid", rv, 0);
        provjeri("reset greska", gr, 0);
        provjeri("reset ulaz_ready", rdy, 1);
        rst_n = 1'b1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "simulation time limit");
    end

    initial begin
        int t0, t1;
        repeat (3) @(negedge clk);
        provjeri("reset uzorak", uz, '0);
        provjeri("reset uzorak_valid", uv, 0);
        provjeri("reset rezultat_valid", rv, 0);
        provjeri("reset greska", gr, 0);
        provjeri("reset ulaz_ready", rdy, 1);
        rst_n = 1'b1;

        // Latency 3: two samples back to back, then one with gaps.
        okvir(1, 0, 59, 60, t0, t1);
        okvir(1001, 0, 59, 60, t0, t1);
        mir(6);
        provjeri("uzorak word 0", uz[15:0], 1001);
        provjeri("uzorak word 59", uz[959:944], 1060);
        provjeri("ulaz_ready never low", niski_a, 0);
        okvir(1, 1, 59, 60, t0, t1);
        provjeri("gapped frame span", t1 - t0, 118);
        mir(6);

`ifdef UZORAK_PUNJAC_OKVIR_EN
        okvir(5000, 0, 10, 11, t0, t1);
`else
        okvir(5000, 0, 10, 60, t0, t1);
`endif
        okvir(6000, 0, 59, 60, t0, t1);
        mir(6);

        // Latency 100: second sample must wait for the first result.
        sel = 1'b1;
        zadnji_prijenos = -1000;
        mir(2);
        okvir(1, 0, 59, 60, t0, t1);
        okvir(2001, 0, 59, 60, t0, t1);
        mir(210);
        provjeri("ulaz_ready low cycles", niski_b, 40);

        // Reset mid-fill, then reset just after a transfer.
        sel = 1'b0;
        mir(2);
        okvir(1, 0, 59, 30, t0, t1);
        resetiraj();
        okvir(7000, 0, 59, 60, t0, t1);
        mir(8);
        okvir(8000, 0, 59, 60, t0, t1);
        mir(1);
        resetiraj();
        mir(10);

        provjeri("pending uzorak_valid", q_vec.size(), 0);
        provjeri("pending rezultat_valid", q_rez.size(), 0);
        provjeri("pending greska", q_gr.size(), 0);
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
